// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
package uart_arb_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned CNT_W       = 17;
    localparam int unsigned DEF_TIMEOUT = 65535;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-side signal bundle of the transmit arbiter.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_clear_req;
    logic                 active;
    logic [IDW-1:0]       grant_id;
    logic                 timeout_err;

    // Arbiter side
    modport slave (
        input  req, req_data, tx_busy, tx_clear_req,
        output ack, tx_start, tx_data, active, grant_id, timeout_err
    );

    // Requesters plus UART side
    modport master (
        output req, req_data, tx_busy, tx_clear_req,
        input  ack, tx_start, tx_data, active, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic               valid,
    output logic [IDW-1:0]     idx
);

    int unsigned k;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        k     = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            k = (32'(rr_ptr) + off) % NUM_REQ;
            if (!valid && req[k]) begin
                valid = 1'b1;
                idx   = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Optional per-byte abort timer enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus
);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    arb_state_t          state;
    logic [IDW-1:0]      rr_ptr;
    logic [IDW-1:0]      grant_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [BYTE_W-1:0]   tx_data_q;
    logic                tx_start_q;
    logic                active_q;
    logic                busy_s1, busy_s;
    logic                clr_s1, clr_s, clr_s_d;
    logic                done_p_c;
    logic                pick_valid_c;
    logic [IDW-1:0]      pick_idx_c;
    logic [IDW-1:0]      next_ptr_c;

    // Status inputs come from the slower UART bit-clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_s1 <= 1'b0;
            busy_s  <= 1'b0;
            clr_s1  <= 1'b0;
            clr_s   <= 1'b0;
            clr_s_d <= 1'b0;
        end else begin
            busy_s1 <= bus.tx_busy;
            busy_s  <= busy_s1;
            clr_s1  <= bus.tx_clear_req;
            clr_s   <= clr_s1;
            clr_s_d <= clr_s;
        end
    end

    // A held clear_req completes a frame only once
    assign done_p_c = clr_s & ~clr_s_d;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid_c),
        .idx    (pick_idx_c)
    );

    assign next_ptr_c = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);

`ifdef UART_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_err_q;
    logic             tmo_hit_c;

    assign tmo_hit_c = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == IDLE) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_err_q  <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid_c) begin
                        state      <= START;
                        tx_data_q  <= bus.req_data[BYTE_W*pick_idx_c +: BYTE_W];
                        grant_q    <= pick_idx_c;
                        ack_q      <= NUM_REQ'(1) << pick_idx_c;
                        tx_start_q <= 1'b1;
                        active_q   <= 1'b1;
                    end
                end
                START: begin
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    // A short frame can end before busy makes it through the synchronizer
                    if (done_p_c) begin
                        state      <= IDLE;
                        tx_start_q <= 1'b0;
                        active_q   <= 1'b0;
                        rr_ptr     <= next_ptr_c;
                    end else if (busy_s) begin
                        state      <= WAIT_DONE;
                        tx_start_q <= 1'b0;
                    end
                end
                WAIT_DONE: begin
                    if (done_p_c) begin
                        state    <= IDLE;
                        active_q <= 1'b0;
                        rr_ptr   <= next_ptr_c;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef UART_ARB_TIMEOUT_EN
            if (tmo_hit_c) begin
                state      <= IDLE;
                tx_start_q <= 1'b0;
                active_q   <= 1'b0;
                rr_ptr     <= next_ptr_c;
                tmo_err_q  <= 1'b1;
            end
`endif
        end
    end

    assign bus.ack      = ack_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.active   = active_q;
    assign bus.grant_id = grant_q;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.timeout_err = tmo_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter against a round-robin reference model.
module tb_uart_tx_arbiter;

    logic clk;
    logic rst_n;

    uart_tx_arbiter_if #(.NUM_REQ(4), .IDW(2)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .IDW            (2),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors;
    int         miscompares;
    int         model_ptr;
    int         cur_id;
    logic [7:0] bytes_m [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data();
        bus.req_data = {bytes_m[3], bytes_m[2], bytes_m[1], bytes_m[0]};
    endtask

    // Reference arbitration: first pending requester at or after the pointer, wrapping
    function automatic int exp_pick(input logic [3:0] m, input int ptr);
        for (int k = 0; k < 4; k++)
            if (m[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    task automatic start_frame(input int exp_id, input logic [3:0] req_after,
                               input int max_wait, input string tag);
        int         n;
        logic [3:0] oh;
        n  = 0;
        oh = 4'b0001 << exp_id;
        do begin
            tick();
            n++;
        end while (bus.ack == 4'b0000 && n < max_wait);
        check({tag, ".ack"},      32'(bus.ack),      32'(oh));
        check({tag, ".grant"},    32'(bus.grant_id), 32'(exp_id));
        check({tag, ".data"},     32'(bus.tx_data),  32'(bytes_m[exp_id]));
        check({tag, ".start"},    32'(bus.tx_start), 32'd1);
        check({tag, ".active"},   32'(bus.active),   32'd1);
        bus.req = req_after;
        cur_id  = exp_id;
        tick();
        check({tag, ".ackpulse"}, 32'(bus.ack),      32'd0);
    endtask

    task automatic end_frame(input int bdly, input int blen, input int clen,
                             input bit skip_busy, input string tag);
        bit seen;
        repeat (bdly) tick();
        if (!skip_busy) begin
            bus.tx_busy = 1'b1;
            tick();
            check({tag, ".hold1"}, 32'(bus.tx_start), 32'd1);
            tick();
            check({tag, ".hold2"}, 32'(bus.tx_start), 32'd1);
            tick();
            check({tag, ".drop"},  32'(bus.tx_start), 32'd0);
            repeat (blen) tick();
            bus.tx_busy = 1'b0;
        end
        check({tag, ".stable"}, 32'(bus.tx_data), 32'(bytes_m[cur_id]));
        bus.tx_clear_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i + 1 == clen) bus.tx_clear_req = 1'b0;
            if (!bus.active) begin
                seen = 1'b1;
                break;
            end
        end
        bus.tx_clear_req = 1'b0;
        check({tag, ".done"},   32'(seen),         32'd1);
        check({tag, ".idlest"}, 32'(bus.tx_start), 32'd0);
        model_ptr = (cur_id + 1) % 4;
    endtask

    initial begin
        logic [3:0] pend;
        int         w;
        bit         seen;

        vectors          = 0;
        miscompares      = 0;
        model_ptr        = 0;
        cur_id           = 0;
        rst_n            = 1'b0;
        bus.req          = 4'b0000;
        bus.req_data     = '0;
        bus.tx_busy      = 1'b0;
        bus.tx_clear_req = 1'b0;
        for (int i = 0; i < 4; i++) bytes_m[i] = 8'h00;

        repeat (3) tick();
        check("rst.ack",    32'(bus.ack),         32'd0);
        check("rst.start",  32'(bus.tx_start),    32'd0);
        check("rst.active", 32'(bus.active),      32'd0);
        check("rst.grant",  32'(bus.grant_id),    32'd0);
        check("rst.data",   32'(bus.tx_data),     32'd0);
        check("rst.tmo",    32'(bus.timeout_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fairness with all four requesters continuously pending
        for (int i = 0; i < 4; i++) bytes_m[i] = 8'(8'h10 + i);
        set_data();
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            start_frame(i % 4, (i == 4) ? 4'b0000 : 4'b1111, 1, "fair");
            end_frame(1, 2, 2, 1'b0, "fair");
        end

        // Single requester
        bytes_m[2] = 8'h41;
        set_data();
        bus.req = 4'b0100;
        start_frame(exp_pick(4'b0100, model_ptr), 4'b0000, 1, "single");
        end_frame(2, 3, 2, 1'b0, "single");
        repeat (4) tick();
        check("single.quiet_ack",    32'(bus.ack),    32'd0);
        check("single.quiet_active", 32'(bus.active), 32'd0);

        // Wrap from the last requester back to zero
        bytes_m[0] = 8'hA0;
        bytes_m[3] = 8'hA3;
        set_data();
        bus.req = 4'b1001;
        start_frame(exp_pick(4'b1001, model_ptr), 4'b0001, 1, "wrap");
        end_frame(0, 1, 1, 1'b0, "wrap");
        start_frame(exp_pick(4'b0001, model_ptr), 4'b0000, 1, "wrap2");
        end_frame(0, 1, 1, 1'b0, "wrap2");

        // Busy never observed; clear_req held long across the next grant
        bytes_m[0] = 8'h5A;
        bytes_m[1] = 8'hC3;
        set_data();
        bus.req = 4'b0011;
        w = exp_pick(4'b0011, model_ptr);
        pend = 4'b0011;
        pend[w] = 1'b0;
        start_frame(w, pend, 1, "miss");
        repeat (2) tick();
        bus.tx_clear_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus.active) begin
                seen = 1'b1;
                break;
            end
        end
        check("miss.done", 32'(seen), 32'd1);
        model_ptr = (w + 1) % 4;
        start_frame(exp_pick(pend, model_ptr), 4'b0000, 1, "miss2");
        repeat (5) tick();
        check("miss.once_active", 32'(bus.active),   32'd1);
        check("miss.once_start",  32'(bus.tx_start), 32'd1);
        bus.tx_clear_req = 1'b0;
        end_frame(1, 2, 2, 1'b0, "miss2");

        // Reset while waiting for the frame to finish
        bytes_m[2] = 8'h77;
        set_data();
        bus.req = 4'b0100;
        start_frame(exp_pick(4'b0100, model_ptr), 4'b0000, 1, "rstmid");
        bus.tx_busy = 1'b1;
        repeat (3) tick();
        check("rstmid.waitdone", 32'(bus.tx_start), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid.start",  32'(bus.tx_start), 32'd0);
        check("rstmid.active", 32'(bus.active),   32'd0);
        check("rstmid.ack",    32'(bus.ack),      32'd0);
        check("rstmid.grant",  32'(bus.grant_id), 32'd0);
        bus.tx_busy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_ptr = 0;
        for (int i = 0; i < 4; i++) bytes_m[i] = 8'(8'hE0 + i);
        set_data();
        bus.req = 4'b1111;
        start_frame(exp_pick(4'b1111, model_ptr), 4'b0000, 1, "postrst");
        end_frame(0, 1, 2, 1'b0, "postrst");

        // UART stalls: no busy and no clear
        bus.req = 4'b0010;
        w = exp_pick(4'b0010, model_ptr);
        start_frame(w, 4'b0000, 1, "stall");
`ifdef UART_ARB_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (!bus.active) begin
                seen = 1'b1;
                break;
            end
        end
        check("tmo.abort", 32'(seen),            32'd1);
        check("tmo.err",   32'(bus.timeout_err), 32'd1);
        check("tmo.start", 32'(bus.tx_start),    32'd0);
        model_ptr = (w + 1) % 4;
`else
        repeat (150) tick();
        check("stall.active", 32'(bus.active),      32'd1);
        check("stall.start",  32'(bus.tx_start),    32'd1);
        check("stall.err",    32'(bus.timeout_err), 32'd0);
        end_frame(0, 2, 2, 1'b0, "stall");
`endif

        // Random request sets, bytes and UART timing
        for (int r = 0; r < 12; r++) begin
            pend = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) bytes_m[i] = 8'($urandom);
            set_data();
            bus.req = pend;
            while (pend != 4'b0000) begin
                w = exp_pick(pend, model_ptr);
                pend[w] = 1'b0;
                start_frame(w, pend, 1, "rnd");
                end_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                          int'($urandom_range(1, 3)), ($urandom_range(0, 4) == 0), "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
